rgbw_fade_ramp: RTL and testbench

Duty-cycle slew stage between colour generation and the PWM generator: takes the four 8-bit RGBW duty targets produced upstream and moves the live duties toward them in bounded steps at a programmable rate. This turns abrupt colour or intensity changes into smooth fades. Outputs drive the PWM generator's duty inputs directly, on the shared prescaled system clock.

---
 rtl/rgbw_fade_ramp_pkg.sv | 23 ++
 rtl/rgbw_fade_ramp_if.sv | 29 ++
 rtl/rgbw_gamma_lut.sv | 34 +++
 rtl/rgbw_fade_ramp.sv | 157 +++++++++++++++
 tb/tb_rgbw_fade_ramp.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rgbw_fade_ramp_pkg.sv
// Shared definitions for the RGBW duty fade ramp: state encoding, duty width
// and channel indices used by the ramp top and its interface.
package rgbw_fade_ramp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  localparam int DUTY_W = 8;
  localparam int NUM_CH = 4;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int CH_W = 3;

  // A programmed rate of zero means "jump in one tick", i.e. the largest step.
  function automatic logic [DUTY_W-1:0] eff_rate(input logic [DUTY_W-1:0] rate);
    return (rate == '0) ? {DUTY_W{1'b1}} : rate;
  endfunction

endpackage

// File: rtl/rgbw_fade_ramp_if.sv
// Target/duty bundle between colour generation (master) and the fade ramp
// (slave), whose duty outputs feed the PWM generator.
interface rgbw_fade_ramp_if;
  import rgbw_fade_ramp_pkg::*;

  logic [DUTY_W-1:0] tgt_r;
  logic [DUTY_W-1:0] tgt_g;
  logic [DUTY_W-1:0] tgt_b;
  logic [DUTY_W-1:0] tgt_w;
  logic              tgt_valid;
  logic [DUTY_W-1:0] rate;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic [DUTY_W-1:0] duty_w;
  logic              busy;
  logic              done;

  modport master (
    output tgt_r, tgt_g, tgt_b, tgt_w, tgt_valid, rate,
    input  duty_r, duty_g, duty_b, duty_w, busy, done
  );

  modport slave (
    input  tgt_r, tgt_g, tgt_b, tgt_w, tgt_valid, rate,
    output duty_r, duty_g, duty_b, duty_w, busy, done
  );

endinterface

// File: rtl/rgbw_gamma_lut.sv
// One registered channel of perceptual correction, out = (d*d + 255) >> 8.
// Only built when RGBW_FADE_GAMMA_EN is defined.
`ifdef RGBW_FADE_GAMMA_EN
module rgbw_gamma_lut (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty_in,
  output logic [7:0] duty_out
);

  logic [15:0] square;
  logic [15:0] biased;
  logic [7:0]  duty_d;
  logic [7:0]  duty_q;

  // The +255 bias keeps 1 mapping to 1 and 255 mapping to 255.
  always_comb begin
    square = {8'd0, duty_in} * {8'd0, duty_in};
    biased = square + 16'd255;
    duty_d = biased[15:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_out = duty_q;

endmodule
`endif

// File: rtl/rgbw_fade_ramp.sv
// Slews four RGBW duties toward latched targets in bounded steps every
// STEP_DIV cycles. Define RGBW_FADE_GAMMA_EN to add registered gamma correction.
module rgbw_fade_ramp
  import rgbw_fade_ramp_pkg::*;
#(
  parameter int STEP_DIV = 256
) (
  input  logic              clk,
  input  logic              reset,
  rgbw_fade_ramp_if.slave   bus
);

  localparam logic [15:0] CNT_LAST = 16'(STEP_DIV - 1);

  typedef logic [NUM_CH-1:0][DUTY_W-1:0] duty_vec_t;

  ramp_state_e       state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  duty_vec_t         tgt_q, tgt_d;
  duty_vec_t         cur_q, cur_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  duty_vec_t         tgt_in;
  duty_vec_t         step_val;
  duty_vec_t         duty_out;
  logic [DUTY_W-1:0] step_size;
  logic              tick;
  logic              all_reached;

  assign tgt_in[CH_R] = bus.tgt_r;
  assign tgt_in[CH_G] = bus.tgt_g;
  assign tgt_in[CH_B] = bus.tgt_b;
  assign tgt_in[CH_W] = bus.tgt_w;

  assign step_size = eff_rate(bus.rate);
  assign tick      = (state_q == RAMP) && (cnt_q == CNT_LAST);

  // Each channel clamps its step at the target, so it can never overshoot or wrap.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DUTY_W:0]   diff_up;
    logic [DUTY_W:0]   diff_dn;
    logic [DUTY_W:0]   step9;
    logic [DUTY_W-1:0] nxt;

    always_comb begin
      diff_up = {1'b0, tgt_q[i]} - {1'b0, cur_q[i]};
      diff_dn = {1'b0, cur_q[i]} - {1'b0, tgt_q[i]};
      step9   = {1'b0, step_size};
      nxt     = cur_q[i];
      if (tgt_q[i] > cur_q[i]) begin
        nxt = (diff_up > step9) ? (cur_q[i] + step_size) : tgt_q[i];
      end else if (tgt_q[i] < cur_q[i]) begin
        nxt = (diff_dn > step9) ? (cur_q[i] - step_size) : tgt_q[i];
      end
    end

    assign step_val[i] = nxt;
  end

  assign all_reached = (step_val == tgt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.tgt_valid) begin
          tgt_d   = tgt_in;
          state_d = RAMP;
        end
      end
      RAMP: begin
        // A new strobe wins over a coincident tick: the step is dropped and
        // the prescaler restarts so the new fade gets a full first period.
        if (bus.tgt_valid) begin
          tgt_d = tgt_in;
          cnt_d = '0;
        end else if (tick) begin
          cnt_d = '0;
          cur_d = step_val;
          if (all_reached) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == RAMP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RGBW_FADE_GAMMA_EN
  logic busy_dly_q;
  logic done_dly_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_gamma
    rgbw_gamma_lut u_gamma (
      .clk      (clk),
      .reset    (reset),
      .duty_in  (cur_q[i]),
      .duty_out (duty_out[i])
    );
  end

  // Status follows the corrected duties through the same one-cycle delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_dly_q <= 1'b0;
      done_dly_q <= 1'b0;
    end else begin
      busy_dly_q <= busy_q;
      done_dly_q <= done_q;
    end
  end

  assign bus.busy = busy_dly_q;
  assign bus.done = done_dly_q;
`else
  assign duty_out = cur_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`endif

  assign bus.duty_r = duty_out[CH_R];
  assign bus.duty_g = duty_out[CH_G];
  assign bus.duty_b = duty_out[CH_B];
  assign bus.duty_w = duty_out[CH_W];

endmodule

// File: tb/tb_rgbw_fade_ramp.sv
// Directed bench for rgbw_fade_ramp with STEP_DIV=4; also covers the
// RGBW_FADE_GAMMA_EN build by shifting checks one cycle and correcting values.
module tb_rgbw_fade_ramp;

`ifdef RGBW_FADE_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  rgbw_fade_ramp_if bus_if ();

  rgbw_fade_ramp #(
    .STEP_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected visible duty for a raw ramp value, including gamma when built in.
  function automatic int exp_duty(input int x);
`ifdef RGBW_FADE_GAMMA_EN
    return (x * x + 255) >> 8;
`else
    return x;
`endif
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one strobe; returns one cycle after the strobe was sampled.
  task automatic apply_stimulus(input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b, input logic [7:0] w,
                                input logic [7:0] rt);
    bus_if.tgt_r     = r;
    bus_if.tgt_g     = g;
    bus_if.tgt_b     = b;
    bus_if.tgt_w     = w;
    bus_if.rate      = rt;
    bus_if.tgt_valid = 1'b1;
    wait_cycles(1);
    bus_if.tgt_valid = 1'b0;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    bus_if.tgt_r     = '0;
    bus_if.tgt_g     = '0;
    bus_if.tgt_b     = '0;
    bus_if.tgt_w     = '0;
    bus_if.rate      = '0;
    bus_if.tgt_valid = 1'b0;

    wait_cycles(3);
    check_output("reset_duty_r", 32'(bus_if.duty_r), 0);
    check_output("reset_duty_g", 32'(bus_if.duty_g), 0);
    check_output("reset_duty_b", 32'(bus_if.duty_b), 0);
    check_output("reset_duty_w", 32'(bus_if.duty_w), 0);
    check_output("reset_busy", 32'(bus_if.busy), 0);
    check_output("reset_done", 32'(bus_if.done), 0);
    reset = 1'b0;

    $display("[TB] idle hold");
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      check_output("idle_duty_r", 32'(bus_if.duty_r), 0);
      check_output("idle_busy", 32'(bus_if.busy), 0);
    end

    $display("[TB] fade up");
    apply_stimulus(8'd10, 8'd0, 8'd0, 8'd0, 8'd3);
    wait_cycles(LAT);
    check_output("up_busy_start", 32'(bus_if.busy), 1);
    wait_cycles(3);
    check_output("up_before_tick", 32'(bus_if.duty_r), 32'(exp_duty(0)));
    wait_cycles(1);
    check_output("up_r3", 32'(bus_if.duty_r), 32'(exp_duty(3)));
    wait_cycles(4);
    check_output("up_r6", 32'(bus_if.duty_r), 32'(exp_duty(6)));
    wait_cycles(4);
    check_output("up_r9", 32'(bus_if.duty_r), 32'(exp_duty(9)));
    check_output("up_no_done", 32'(bus_if.done), 0);
    wait_cycles(4);
    check_output("up_r10", 32'(bus_if.duty_r), 32'(exp_duty(10)));
    check_output("up_done", 32'(bus_if.done), 1);
    check_output("up_busy_end", 32'(bus_if.busy), 0);
    wait_cycles(1);
    check_output("up_done_pulse", 32'(bus_if.done), 0);

    $display("[TB] fade down");
    apply_stimulus(8'd0, 8'd0, 8'd0, 8'd0, 8'd4);
    wait_cycles(LAT + 4);
    check_output("dn_r6", 32'(bus_if.duty_r), 32'(exp_duty(6)));
    wait_cycles(4);
    check_output("dn_r2", 32'(bus_if.duty_r), 32'(exp_duty(2)));
    wait_cycles(4);
    check_output("dn_r0", 32'(bus_if.duty_r), 0);
    check_output("dn_done", 32'(bus_if.done), 1);

    apply_stimulus(8'd0, 8'd0, 8'd0, 8'd0, 8'd4);
    wait_cycles(LAT);
    check_output("same_busy", 32'(bus_if.busy), 1);
    check_output("same_no_done", 32'(bus_if.done), 0);
    wait_cycles(4);
    check_output("same_done", 32'(bus_if.done), 1);
    check_output("same_r", 32'(bus_if.duty_r), 0);
    check_output("same_busy_end", 32'(bus_if.busy), 0);

    $display("[TB] jump");
    apply_stimulus(8'd200, 8'd100, 8'd50, 8'd255, 8'd0);
    wait_cycles(LAT + 3);
    check_output("jump_no_done", 32'(bus_if.done), 0);
    wait_cycles(1);
    check_output("jump_r", 32'(bus_if.duty_r), 32'(exp_duty(200)));
    check_output("jump_g", 32'(bus_if.duty_g), 32'(exp_duty(100)));
    check_output("jump_b", 32'(bus_if.duty_b), 32'(exp_duty(50)));
    check_output("jump_w", 32'(bus_if.duty_w), 32'(exp_duty(255)));
    check_output("jump_done", 32'(bus_if.done), 1);

    $display("[TB] retarget");
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    apply_stimulus(8'd0, 8'd100, 8'd0, 8'd0, 8'd10);
    wait_cycles(12 + LAT);
    check_output("rt_g30", 32'(bus_if.duty_g), 32'(exp_duty(30)));
    wait_cycles(3 - LAT);
    apply_stimulus(8'd0, 8'd0, 8'd0, 8'd0, 8'd10);
    wait_cycles(LAT);
    check_output("rt_suppressed", 32'(bus_if.duty_g), 32'(exp_duty(30)));
    check_output("rt_no_done0", 32'(bus_if.done), 0);
    wait_cycles(3);
    check_output("rt_hold", 32'(bus_if.duty_g), 32'(exp_duty(30)));
    wait_cycles(1);
    check_output("rt_g20", 32'(bus_if.duty_g), 32'(exp_duty(20)));
    check_output("rt_no_done1", 32'(bus_if.done), 0);
    wait_cycles(4);
    check_output("rt_g10", 32'(bus_if.duty_g), 32'(exp_duty(10)));
    check_output("rt_no_done2", 32'(bus_if.done), 0);
    wait_cycles(4);
    check_output("rt_g0", 32'(bus_if.duty_g), 0);
    check_output("rt_done", 32'(bus_if.done), 1);

    $display("[TB] reset mid-fade");
    apply_stimulus(8'd50, 8'd50, 8'd50, 8'd50, 8'd5);
    wait_cycles(6);
    check_output("mid_r5", 32'(bus_if.duty_r), 32'(exp_duty(5)));
    check_output("mid_busy", 32'(bus_if.busy), 1);
    reset            = 1'b1;
    bus_if.tgt_valid = 1'b1;
    wait_cycles(1);
    check_output("mid_rst_r", 32'(bus_if.duty_r), 0);
    check_output("mid_rst_w", 32'(bus_if.duty_w), 0);
    check_output("mid_rst_busy", 32'(bus_if.busy), 0);
    check_output("mid_rst_done", 32'(bus_if.done), 0);
    reset            = 1'b0;
    bus_if.tgt_valid = 1'b0;
    wait_cycles(8);
    check_output("post_rst_r", 32'(bus_if.duty_r), 0);
    check_output("post_rst_busy", 32'(bus_if.busy), 0);

    $display("[TB] correction values");
    apply_stimulus(8'd128, 8'd1, 8'd255, 8'd0, 8'd0);
    wait_cycles(4);
`ifdef RGBW_FADE_GAMMA_EN
    check_output("gam_early_r", 32'(bus_if.duty_r), 0);
    check_output("gam_early_done", 32'(bus_if.done), 0);
    wait_cycles(1);
    check_output("gam_r", 32'(bus_if.duty_r), 64);
    check_output("gam_g", 32'(bus_if.duty_g), 1);
    check_output("gam_b", 32'(bus_if.duty_b), 255);
    check_output("gam_w", 32'(bus_if.duty_w), 0);
    check_output("gam_done", 32'(bus_if.done), 1);
`else
    check_output("raw_r", 32'(bus_if.duty_r), 128);
    check_output("raw_g", 32'(bus_if.duty_g), 1);
    check_output("raw_b", 32'(bus_if.duty_b), 255);
    check_output("raw_w", 32'(bus_if.duty_w), 0);
    check_output("raw_done", 32'(bus_if.done), 1);
`endif
    wait_cycles(1);
    check_output("final_done_clear", 32'(bus_if.done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
